// File: rtl/dmem_sized.sv
// Byte-addressed data memory with sized loads/stores, registered read port
// and a clear sequencer that zeroes the array after every reset.
`timescale 1ns/1ps
module dmem_sized #(
    parameter int DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic [31:0] RData,
    output logic        RValid,
    output logic        Ready,
    output logic        MisAlign,
    output logic        AddrErr
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, ptr_nx;
    logic [31:0]   mem [DEPTH];

    logic [IW-1:0] idx;
    logic [1:0]    lane;
    logic          mis, oor, ok, act;
    logic [3:0]    be;
    logic [31:0]   wd, rword, shd, ld;

    assign idx   = Addr[IW+1:2];
    assign lane  = Addr[1:0];
    assign act   = (state == IDLE);
    assign Ready = act;

    assign oor = (Addr[31:2] >= 30'(DEPTH));
    assign ok  = !mis && !oor;

    always_comb begin
        mis = 1'b0;
        be  = 4'b0000;
        wd  = Wdata;
        case (Size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{Wdata[7:0]}};
            end
            2'b01: begin
                mis = Addr[0];
                be  = Addr[1] ? 4'b1100 : 4'b0011;
                wd  = {2{Wdata[15:0]}};
            end
            2'b10: begin
                mis = (lane != 2'b00);
                be  = 4'b1111;
            end
            default: mis = 1'b1;
        endcase
    end

    // Out-of-range reads never index the array.
    assign rword = oor ? 32'h0 : mem[idx];
    assign shd   = rword >> {lane, 3'b000};

    always_comb begin
        ld = rword;
        case (Size)
            2'b00:   ld = {{24{~Unsigned & shd[7]}}, shd[7:0]};
            2'b01:   ld = {{16{~Unsigned & shd[15]}}, shd[15:0]};
            default: ld = rword;
        endcase
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        if (state == CLEAR) begin
            ptr_nx = ptr + IW'(1);
            if (ptr == LAST) begin
                state_nx = IDLE;
                ptr_nx   = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Array has no reset; read-first falls out of nonblocking update.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[ptr] <= 32'h0;
            end else if (MemWrite && ok) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RData    <= 32'h0;
            RValid   <= 1'b0;
            MisAlign <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            RValid   <= act && MemRead;
            MisAlign <= act && (MemRead || MemWrite) && mis;
            AddrErr  <= act && (MemRead || MemWrite) && oor;
            RData    <= (act && MemRead && ok) ? ld : 32'h0;
        end
    end
endmodule
